rr_onehot_arbiter: RTL

Sequential round-robin arbiter that turns up to 16 request lines into a registered one-hot grant vector. It sits directly upstream of the 16-to-4 one-hot encoder. Its `grant_out` drives the encoder's 16-bit one-hot input, and its `grant_valid` drives the encoder's enable. The one-hot guarantee of `grant_out` is the property the downstream encoder depends on.

---
 rtl/rr_onehot_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_onehot_arbiter
// Description : Round-robin arbiter for 16 level-sensitive request lines.
//               Produces a registered one-hot grant (all-zero or exactly one
//               bit set) for a downstream 16-to-4 one-hot encoder. A grant is
//               released by done_in, loss of the owner's request, enable low,
//               or expiry of an optional hold limit (MAX_HOLD, 0 = unlimited).
//               Every release is followed by at least one all-zero cycle.
//               Optional feature macro: RR_ARB_GRANT_ID_EN adds a registered
//               4-bit grant_id output carrying the owner index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_onehot_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] req_in,
    input  logic        done_in,
    output logic [15:0] grant_out,
    output logic        grant_valid,
    output logic        forced_rel
`ifdef RR_ARB_GRANT_ID_EN
    ,
    output logic [3:0]  grant_id
`endif
);

    localparam logic [0:0] c_IDLE       = 1'b0;
    localparam logic [0:0] c_GRANT      = 1'b1;
    localparam logic [7:0] c_HOLD_LIMIT = MAX_HOLD[7:0];
    localparam logic       c_HOLD_EN    = (MAX_HOLD != 0);
    localparam logic [7:0] c_HOLD_SAT   = 8'hFF;

    logic [0:0]  state_q,       state_d;
    logic [3:0]  ptr_q,         ptr_d;
    logic [3:0]  owner_q,       owner_d;
    logic [7:0]  hold_cnt_q,    hold_cnt_d;
    logic [15:0] grant_out_q,   grant_out_d;
    logic        grant_valid_q, grant_valid_d;
    logic        forced_rel_q,  forced_rel_d;
`ifdef RR_ARB_GRANT_ID_EN
    logic [3:0]  grant_id_q,    grant_id_d;
`endif

    logic        w_sel_found;
    logic [3:0]  w_sel_idx;
    logic        w_start;
    logic        w_rel_user;
    logic        w_rel_timer;
    logic        w_release;

    // Pick the first requester at or after ptr, wrapping modulo 16
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (!w_sel_found && req_in[ptr_q + 4'(i)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = ptr_q + 4'(i);
            end
        end
    end

    // Start and release qualifiers; user causes suppress the forced-release flag
    always_comb begin
        w_start     = enable & w_sel_found;
        w_rel_user  = done_in | ~req_in[owner_q] | ~enable;
        w_rel_timer = c_HOLD_EN & (hold_cnt_q == c_HOLD_LIMIT);
        w_release   = w_rel_user | w_rel_timer;
    end

    // State register and all flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= c_IDLE;
            ptr_q         <= 4'd0;
            owner_q       <= 4'd0;
            hold_cnt_q    <= 8'd0;
            grant_out_q   <= 16'h0000;
            grant_valid_q <= 1'b0;
            forced_rel_q  <= 1'b0;
`ifdef RR_ARB_GRANT_ID_EN
            grant_id_q    <= 4'd0;
`endif
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_out_q   <= grant_out_d;
            grant_valid_q <= grant_valid_d;
            forced_rel_q  <= forced_rel_d;
`ifdef RR_ARB_GRANT_ID_EN
            grant_id_q    <= grant_id_d;
`endif
        end
    end

    // Next-state: FSM state, rotation pointer, owner and hold counter
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            c_IDLE: begin
                if (w_start) begin
                    state_d    = c_GRANT;
                    owner_d    = w_sel_idx;
                    hold_cnt_d = 8'd1;
                end
            end
            c_GRANT: begin
                if (w_release) begin
                    state_d    = c_IDLE;
                    ptr_d      = owner_q + 4'd1;
                    hold_cnt_d = 8'd0;
                end else if (hold_cnt_q != c_HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // Output next values; release always yields a zero cycle before any new grant
    always_comb begin
        grant_out_d   = 16'h0000;
        grant_valid_d = 1'b0;
        forced_rel_d  = 1'b0;
`ifdef RR_ARB_GRANT_ID_EN
        grant_id_d    = 4'd0;
`endif
        case (state_q)
            c_IDLE: begin
                if (w_start) begin
                    grant_out_d   = 16'd1 << w_sel_idx;
                    grant_valid_d = 1'b1;
`ifdef RR_ARB_GRANT_ID_EN
                    grant_id_d    = w_sel_idx;
`endif
                end
            end
            c_GRANT: begin
                if (w_release) begin
                    forced_rel_d = w_rel_timer & ~w_rel_user;
                end else begin
                    grant_out_d   = grant_out_q;
                    grant_valid_d = 1'b1;
`ifdef RR_ARB_GRANT_ID_EN
                    grant_id_d    = owner_q;
`endif
                end
            end
            default: begin
                grant_out_d = 16'h0000;
            end
        endcase
    end

    assign grant_out   = grant_out_q;
    assign grant_valid = grant_valid_q;
    assign forced_rel  = forced_rel_q;
`ifdef RR_ARB_GRANT_ID_EN
    assign grant_id    = grant_id_q;
`endif

endmodule
`default_nettype wire
